// File: rtl/addsub_scheduler_if.sv
// Request/acknowledge and result bus for the two-requester 8-bit add/sub scheduler.
// Signal prefixes are from the scheduler's point of view.
interface addsub_scheduler_if;
  logic       i_req0;
  logic [7:0] i_a0;
  logic [7:0] i_b0;
  logic       i_p0;
  logic       o_ack0;
  logic       i_req1;
  logic [7:0] i_a1;
  logic [7:0] i_b1;
  logic       i_p1;
  logic       o_ack1;
  logic [7:0] o_s;
  logic       o_co;
  logic       o_done;
  logic       o_done_id;
  logic       o_busy;

  modport master (
    output i_req0, i_a0, i_b0, i_p0, i_req1, i_a1, i_b1, i_p1,
    input  o_ack0, o_ack1, o_s, o_co, o_done, o_done_id, o_busy
  );

  modport slave (
    input  i_req0, i_a0, i_b0, i_p0, i_req1, i_a1, i_b1, i_p1,
    output o_ack0, o_ack1, o_s, o_co, o_done, o_done_id, o_busy
  );
endinterface

// File: rtl/addsub_scheduler.sv
// Two-requester 8-bit add/subtract unit: round-robin arbitration, then two
// 4-bit passes (low nibble, high nibble) through one shared add/sub slice.
module addsub_scheduler (
  input  logic                i_clk,
  input  logic                i_rst,
  addsub_scheduler_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_LOW  = 2'b01,
    ST_HIGH = 2'b10,
    ST_DONE = 2'b11
  } state_t;

  state_t     r_state;
  state_t     w_next;
  logic       w_grant;
  logic       w_grant_id;

  logic       r_ptr;
  logic       r_id;
  logic [7:0] r_a;
  logic [7:0] r_b;
  logic       r_p;
  logic [7:0] r_s;
  logic       r_c4;
  logic       r_co;
  logic       r_ack0;
  logic       r_ack1;
  logic       r_done;
  logic       r_done_id;

  logic [3:0] w_slice_a;
  logic [3:0] w_slice_b;
  logic       w_slice_cin;
  logic [4:0] w_slice_sum;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_next     = r_state;
    w_grant    = 1'b0;
    w_grant_id = r_ptr;
    case (r_state)
      ST_IDLE: begin
        if (bus.i_req0 || bus.i_req1) begin
          w_grant    = 1'b1;
          w_grant_id = (bus.i_req0 && bus.i_req1) ? r_ptr : bus.i_req1;
          w_next     = ST_LOW;
        end
      end
      ST_LOW:  w_next = ST_HIGH;
      ST_HIGH: w_next = ST_DONE;
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  // Shared slice: the low pass takes the requester's mode as carry-in, the high pass takes C4.
  always_comb begin
    w_slice_a   = (r_state == ST_HIGH) ? r_a[7:4] : r_a[3:0];
    w_slice_b   = ((r_state == ST_HIGH) ? r_b[7:4] : r_b[3:0]) ^ {4{r_p}};
    w_slice_cin = (r_state == ST_HIGH) ? r_c4 : r_p;
    w_slice_sum = {1'b0, w_slice_a} + {1'b0, w_slice_b} + {4'b0000, w_slice_cin};
  end

  // NOTE: operand latches are always loaded at grant before being read, so they carry no reset.
  always_ff @(posedge i_clk) begin
    if (w_grant && !i_rst) begin
      r_a <= w_grant_id ? bus.i_a1 : bus.i_a0;
      r_b <= w_grant_id ? bus.i_b1 : bus.i_b0;
      r_p <= w_grant_id ? bus.i_p1 : bus.i_p0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ptr     <= 1'b0;
      r_id      <= 1'b0;
      r_s       <= 8'h00;
      r_c4      <= 1'b0;
      r_co      <= 1'b0;
      r_ack0    <= 1'b0;
      r_ack1    <= 1'b0;
      r_done    <= 1'b0;
      r_done_id <= 1'b0;
    end else begin
      r_ack0 <= w_grant && !w_grant_id;
      r_ack1 <= w_grant && w_grant_id;
      r_done <= (r_state == ST_DONE);
      if (w_grant) r_id <= w_grant_id;
      if (r_state == ST_LOW) begin
        r_s[3:0] <= w_slice_sum[3:0];
        r_c4     <= w_slice_sum[4];
      end
      if (r_state == ST_HIGH) begin
        r_s[7:4] <= w_slice_sum[3:0];
        r_co     <= w_slice_sum[4];
      end
      if (r_state == ST_DONE) begin
        r_done_id <= r_id;
        r_ptr     <= ~r_id;
      end
    end
  end

  assign bus.o_ack0    = r_ack0;
  assign bus.o_ack1    = r_ack1;
  assign bus.o_s       = r_s;
  assign bus.o_co      = r_co;
  assign bus.o_done    = r_done;
  assign bus.o_done_id = r_done_id;
  assign bus.o_busy    = (r_state != ST_IDLE);

endmodule

// File: tb/tb_addsub_scheduler.sv
// Directed bench for addsub_scheduler: add, subtract, wrap, contention,
// reset during an operation and operand stability, with hand-computed results.
module tb_addsub_scheduler;
  logic clk = 1'b0;
  logic rst;
  int   vectors = 0;
  int   miscompares = 0;

  addsub_scheduler_if bus ();

  addsub_scheduler dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic id, input logic [7:0] a, input logic [7:0] b, input logic p);
    if (id == 1'b0) begin
      bus.i_a0 = a; bus.i_b0 = b; bus.i_p0 = p; bus.i_req0 = 1'b1;
    end else begin
      bus.i_a1 = a; bus.i_b1 = b; bus.i_p1 = p; bus.i_req1 = 1'b1;
    end
  endtask

  // Returns cycles until either ACK is seen, or -1 after 16 cycles.
  task automatic wait_ack(output int n, output logic a0, output logic a1);
    n = -1; a0 = 1'b0; a1 = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      tick();
      if (bus.o_ack0 === 1'b1 || bus.o_ack1 === 1'b1) begin
        n = i; a0 = bus.o_ack0; a1 = bus.o_ack1;
        break;
      end
    end
  endtask

  task automatic wait_done(output int n);
    n = -1;
    for (int i = 1; i <= 16; i++) begin
      tick();
      if (bus.o_done === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    issue(1'b0, 8'hAA, 8'h55, 1'b0);
    issue(1'b1, 8'h11, 8'h22, 1'b1);
    tick();
    tick();
    vectors++; if (bus.o_ack0 !== 1'b0 || bus.o_ack1 !== 1'b0) begin miscompares++; $display("FAIL reset_ack: got %b%b want 00", bus.o_ack0, bus.o_ack1); end
    vectors++; if (bus.o_busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", bus.o_busy); end
    vectors++; if (bus.o_done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b want 0", bus.o_done); end
    vectors++; if (bus.o_s !== 8'h00 || bus.o_co !== 1'b0 || bus.o_done_id !== 1'b0) begin miscompares++; $display("FAIL reset_result: got s=%h co=%b id=%b want 00/0/0", bus.o_s, bus.o_co, bus.o_done_id); end
    bus.i_req0 = 1'b0; bus.i_req1 = 1'b0;
    rst = 1'b0;
    tick();
    vectors++; if (bus.o_busy !== 1'b0) begin miscompares++; $display("FAIL reset_idle_busy: got %b want 0", bus.o_busy); end
  endtask

  task automatic test_add();
    int n; logic a0, a1;
    issue(1'b0, 8'h3C, 8'h0F, 1'b0);
    wait_ack(n, a0, a1);
    bus.i_req0 = 1'b0;
    vectors++; if (n !== 1) begin miscompares++; $display("FAIL add_ack_latency: got %0d want 1", n); end
    vectors++; if (a0 !== 1'b1 || a1 !== 1'b0) begin miscompares++; $display("FAIL add_ack_id: got %b%b want 10", a0, a1); end
    wait_done(n);
    vectors++; if (n !== 3) begin miscompares++; $display("FAIL add_done_latency: got %0d want 3", n); end
    vectors++; if (bus.o_s !== 8'h4B || bus.o_co !== 1'b0) begin miscompares++; $display("FAIL add_result: got s=%h co=%b want 4b/0", bus.o_s, bus.o_co); end
    vectors++; if (bus.o_done_id !== 1'b0) begin miscompares++; $display("FAIL add_done_id: got %b want 0", bus.o_done_id); end
    vectors++; if (dut.r_c4 !== 1'b1) begin miscompares++; $display("FAIL add_c4: got %b want 1", dut.r_c4); end
    vectors++; if (bus.o_busy !== 1'b0) begin miscompares++; $display("FAIL add_busy_at_done: got %b want 0", bus.o_busy); end
    tick();
    vectors++; if (bus.o_done !== 1'b0) begin miscompares++; $display("FAIL add_done_pulse_width: got %b want 0", bus.o_done); end
  endtask

  task automatic test_sub();
    int n; logic a0, a1;
    issue(1'b1, 8'h05, 8'h07, 1'b1);
    wait_ack(n, a0, a1);
    bus.i_req1 = 1'b0;
    vectors++; if (n !== 1 || a1 !== 1'b1 || a0 !== 1'b0) begin miscompares++; $display("FAIL sub_borrow_ack: got n=%0d ack=%b%b want 1/01", n, a0, a1); end
    wait_done(n);
    vectors++; if (n !== 3) begin miscompares++; $display("FAIL sub_borrow_latency: got %0d want 3", n); end
    vectors++; if (bus.o_s !== 8'hFE || bus.o_co !== 1'b0 || bus.o_done_id !== 1'b1) begin miscompares++; $display("FAIL sub_borrow_result: got s=%h co=%b id=%b want fe/0/1", bus.o_s, bus.o_co, bus.o_done_id); end
    issue(1'b1, 8'h07, 8'h05, 1'b1);
    wait_ack(n, a0, a1);
    bus.i_req1 = 1'b0;
    vectors++; if (n !== 1 || a1 !== 1'b1) begin miscompares++; $display("FAIL sub_noborrow_ack: got n=%0d ack1=%b want 1/1", n, a1); end
    wait_done(n);
    vectors++; if (n !== 3 || bus.o_s !== 8'h02 || bus.o_co !== 1'b1 || bus.o_done_id !== 1'b1) begin miscompares++; $display("FAIL sub_noborrow_result: got n=%0d s=%h co=%b id=%b want 3/02/1/1", n, bus.o_s, bus.o_co, bus.o_done_id); end
  endtask

  task automatic test_wrap();
    int n; logic a0, a1;
    issue(1'b0, 8'hFF, 8'h01, 1'b0);
    wait_ack(n, a0, a1);
    bus.i_req0 = 1'b0;
    wait_done(n);
    vectors++; if (n !== 3 || bus.o_s !== 8'h00 || bus.o_co !== 1'b1 || bus.o_done_id !== 1'b0) begin miscompares++; $display("FAIL wrap_result: got n=%0d s=%h co=%b id=%b want 3/00/1/0", n, bus.o_s, bus.o_co, bus.o_done_id); end
  endtask

  task automatic test_contention();
    int n; logic a0, a1; logic exp0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    issue(1'b0, 8'h10, 8'h20, 1'b0);
    issue(1'b1, 8'h50, 8'h10, 1'b1);
    wait_ack(n, a0, a1);
    bus.i_req0 = 1'b0;
    vectors++; if (n !== 1 || a0 !== 1'b1 || a1 !== 1'b0) begin miscompares++; $display("FAIL contend_first_grant: got n=%0d ack=%b%b want 1/10", n, a0, a1); end
    wait_done(n);
    vectors++; if (n !== 3 || bus.o_done_id !== 1'b0 || bus.o_s !== 8'h30) begin miscompares++; $display("FAIL contend_first_done: got n=%0d id=%b s=%h want 3/0/30", n, bus.o_done_id, bus.o_s); end
    wait_ack(n, a0, a1);
    bus.i_req1 = 1'b0;
    vectors++; if (n !== 1 || a1 !== 1'b1 || a0 !== 1'b0) begin miscompares++; $display("FAIL contend_second_grant: got n=%0d ack=%b%b want 1/01", n, a0, a1); end
    wait_done(n);
    vectors++; if (n !== 3 || bus.o_done_id !== 1'b1 || bus.o_s !== 8'h40 || bus.o_co !== 1'b1) begin miscompares++; $display("FAIL contend_second_done: got n=%0d id=%b s=%h co=%b want 3/1/40/1", n, bus.o_done_id, bus.o_s, bus.o_co); end
    bus.i_req0 = 1'b1;
    bus.i_req1 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp0 = (i % 2 == 0);
      wait_ack(n, a0, a1);
      vectors++; if (n !== ((i == 0) ? 1 : 4) || a0 !== exp0 || a1 !== !exp0) begin miscompares++; $display("FAIL contend_alternate[%0d]: got n=%0d ack=%b%b want %0d/%b%b", i, n, a0, a1, (i == 0) ? 1 : 4, exp0, !exp0); end
    end
    bus.i_req0 = 1'b0;
    bus.i_req1 = 1'b0;
    wait_done(n);
    vectors++; if (n !== 3 || bus.o_done_id !== 1'b1 || bus.o_s !== 8'h40) begin miscompares++; $display("FAIL contend_last_done: got n=%0d id=%b s=%h want 3/1/40", n, bus.o_done_id, bus.o_s); end
  endtask

  task automatic test_reset_mid_op();
    int n; logic a0, a1;
    issue(1'b1, 8'h12, 8'h34, 1'b0);
    wait_ack(n, a0, a1);
    vectors++; if (n !== 1 || a1 !== 1'b1) begin miscompares++; $display("FAIL midrst_ack: got n=%0d ack1=%b want 1/1", n, a1); end
    tick();
    vectors++; if (bus.o_busy !== 1'b1 || bus.o_done !== 1'b0) begin miscompares++; $display("FAIL midrst_in_high: got busy=%b done=%b want 1/0", bus.o_busy, bus.o_done); end
    rst = 1'b1;
    tick();
    vectors++; if (bus.o_done !== 1'b0 || bus.o_busy !== 1'b0 || bus.o_ack0 !== 1'b0 || bus.o_ack1 !== 1'b0) begin miscompares++; $display("FAIL midrst_ctrl: got done=%b busy=%b ack=%b%b want 0/0/00", bus.o_done, bus.o_busy, bus.o_ack0, bus.o_ack1); end
    vectors++; if (bus.o_s !== 8'h00 || bus.o_co !== 1'b0 || bus.o_done_id !== 1'b0) begin miscompares++; $display("FAIL midrst_result: got s=%h co=%b id=%b want 00/0/0", bus.o_s, bus.o_co, bus.o_done_id); end
    rst = 1'b0;
    wait_ack(n, a0, a1);
    bus.i_req1 = 1'b0;
    vectors++; if (n !== 1 || a1 !== 1'b1 || a0 !== 1'b0) begin miscompares++; $display("FAIL midrst_regrant: got n=%0d ack=%b%b want 1/01", n, a0, a1); end
    wait_done(n);
    vectors++; if (n !== 3 || bus.o_s !== 8'h46 || bus.o_co !== 1'b0 || bus.o_done_id !== 1'b1) begin miscompares++; $display("FAIL midrst_result_after: got n=%0d s=%h co=%b id=%b want 3/46/0/1", n, bus.o_s, bus.o_co, bus.o_done_id); end
  endtask

  task automatic test_operand_stability();
    int n; logic a0, a1;
    issue(1'b0, 8'h25, 8'h11, 1'b1);
    wait_ack(n, a0, a1);
    bus.i_a0 = 8'hFF; bus.i_b0 = 8'hFF; bus.i_p0 = 1'b0; bus.i_req0 = 1'b0;
    vectors++; if (n !== 1 || a0 !== 1'b1) begin miscompares++; $display("FAIL stable_ack: got n=%0d ack0=%b want 1/1", n, a0); end
    tick();
    vectors++; if (bus.o_s[3:0] !== 4'h4 || bus.o_done !== 1'b0 || bus.o_busy !== 1'b1) begin miscompares++; $display("FAIL stable_low_nibble: got s_lo=%h done=%b busy=%b want 4/0/1", bus.o_s[3:0], bus.o_done, bus.o_busy); end
    bus.i_a0 = 8'h00; bus.i_b0 = 8'h80;
    wait_done(n);
    vectors++; if (n !== 2 || bus.o_s !== 8'h14 || bus.o_co !== 1'b1 || bus.o_done_id !== 1'b0) begin miscompares++; $display("FAIL stable_result: got n=%0d s=%h co=%b id=%b want 2/14/1/0", n, bus.o_s, bus.o_co, bus.o_done_id); end
  endtask

  initial begin
    rst = 1'b1;
    bus.i_req0 = 1'b0; bus.i_a0 = 8'h00; bus.i_b0 = 8'h00; bus.i_p0 = 1'b0;
    bus.i_req1 = 1'b0; bus.i_a1 = 8'h00; bus.i_b1 = 8'h00; bus.i_p1 = 1'b0;
    test_reset();
    test_add();
    test_sub();
    test_wrap();
    test_contention();
    test_reset_mid_op();
    test_operand_stability();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
